ranc_tick_sequencer: RTL and testbench

Synthesizable sequencer that drives a RANC network grid: it issues `tick` at a programmable period and streams each frame's input packets from an external packet ROM into the grid's input-buffer handshake. It also collects the grid's output spikes into one vector per frame, correcting for network layer latency. It sits between the frame/packet memories and the `RANCNetworkGrid_*` top, replacing bench-side stimulus for on-chip and FPGA runs.

---
 rtl/ranc_tick_sequencer_if.sv | 31 +++
 rtl/ranc_tick_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ranc_tick_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ranc_tick_sequencer_if.sv
// Grid-side signal bundle between the tick sequencer (master) and a RANC network grid (slave).
// Handshake: one packet moves on each rising edge where ren_to_input_buffer is high and input_buffer_empty is low; its data is on packet_in in the following cycle.
interface ranc_tick_sequencer_if #(
    parameter int PACKET_WIDTH = 30,
    parameter int OUT_ID_WIDTH = 8
);
    logic                    tick;
    logic                    input_buffer_empty;
    logic                    ren_to_input_buffer;
    logic [PACKET_WIDTH-1:0] packet_in;
    logic [OUT_ID_WIDTH-1:0] packet_out;
    logic                    packet_out_valid;

    modport master (
        output tick,
        output input_buffer_empty,
        output packet_in,
        input  ren_to_input_buffer,
        input  packet_out,
        input  packet_out_valid
    );

    modport slave (
        input  tick,
        input  input_buffer_empty,
        input  packet_in,
        output ren_to_input_buffer,
        output packet_out,
        output packet_out_valid
    );
endinterface

// File: rtl/ranc_tick_sequencer.sv
// Drives a RANC grid: periodic tick, per-frame packet streaming from ROM, and
// per-frame spike capture delayed by the network layer latency.
module ranc_tick_sequencer #(
    parameter int PACKET_WIDTH = 30,
    parameter int COUNT_WIDTH  = 7,
    parameter int ADDR_WIDTH   = 12,
    parameter int FRAME_WIDTH  = 14,
    parameter int PERIOD_WIDTH = 16,
    parameter int OUT_ID_WIDTH = 8,
    parameter int NUM_OUTPUT   = 250,
    parameter int NUM_LAYERS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [FRAME_WIDTH-1:0]  num_frames,
    input  logic [PERIOD_WIDTH-1:0] tick_period,
    input  logic [PERIOD_WIDTH-1:0] init_wait,
    output logic [FRAME_WIDTH-1:0]  cnt_addr,
    input  logic [COUNT_WIDTH-1:0]  cnt_rdata,
    output logic [ADDR_WIDTH-1:0]   pkt_addr,
    input  logic [PACKET_WIDTH-1:0] pkt_rdata,
    ranc_tick_sequencer_if.master   grid,
    output logic [NUM_OUTPUT-1:0]   spike_vec,
    output logic                    spike_vec_valid,
    output logic [FRAME_WIDTH-1:0]  spike_frame,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun_error,
    output logic [2:0]              state_dbg
);
    localparam int TW = FRAME_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_TICK = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [FRAME_WIDTH-1:0]  num_frames_r;
    logic [FRAME_WIDTH-1:0]  frame_idx;
    logic [PERIOD_WIDTH-1:0] period_r;
    logic [PERIOD_WIDTH-1:0] wait_cnt;
    logic [TW-1:0]           tick_cnt;
    logic [TW-1:0]           tick_cnt_new;
    logic [TW-1:0]           tick_total;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [NUM_OUTPUT-1:0]   acc;
    logic [NUM_OUTPUT-1:0]   acc_set;
    logic                    active;
    logic                    ibe;
    logic                    serve;
    logic                    underrun_hit;

    assign tick_cnt_new = tick_cnt + 1'b1;
    assign tick_total   = {1'b0, num_frames_r} + TW'(NUM_LAYERS);
    assign active       = (state == S_TICK) || (state == S_RUN);
    assign ibe          = !active || (remaining == '0);
    assign serve        = grid.ren_to_input_buffer && !ibe;
    assign underrun_hit = grid.ren_to_input_buffer && ibe;

    // Ids at or above NUM_OUTPUT never match a bit position and are dropped.
    always_comb begin
        acc_set = '0;
        for (int i = 0; i < NUM_OUTPUT; i++) begin
            if (grid.packet_out_valid && (int'(grid.packet_out) == NUM_OUTPUT - 1 - i))
                acc_set[i] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_frames == '0)
                        state_nxt = S_DONE;
                    else if (init_wait == '0)
                        state_nxt = S_TICK;
                    else
                        state_nxt = S_INIT;
                end
            end
            S_INIT:  if (wait_cnt <= PERIOD_WIDTH'(1)) state_nxt = S_TICK;
            S_TICK:  state_nxt = (tick_cnt_new == tick_total) ? S_DONE : S_RUN;
            S_RUN:   if (wait_cnt <= PERIOD_WIDTH'(1)) state_nxt = S_TICK;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            num_frames_r    <= '0;
            frame_idx       <= '0;
            period_r        <= '0;
            wait_cnt        <= '0;
            tick_cnt        <= '0;
            remaining       <= '0;
            rd_ptr          <= '0;
            acc             <= '0;
            spike_vec       <= '0;
            spike_vec_valid <= 1'b0;
            spike_frame     <= '0;
            underrun_error  <= 1'b0;
        end else begin
            state           <= state_nxt;
            spike_vec_valid <= 1'b0;
            acc             <= acc | acc_set;
            if (serve) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (underrun_hit)
                underrun_error <= 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_frames_r   <= num_frames;
                        period_r       <= (tick_period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : tick_period;
                        wait_cnt       <= init_wait;
                        frame_idx      <= '0;
                        tick_cnt       <= '0;
                        rd_ptr         <= '0;
                        remaining      <= '0;
                        acc            <= '0;
                        underrun_error <= 1'b0;
                    end
                end
                S_INIT, S_RUN: wait_cnt <= wait_cnt - 1'b1;
                S_TICK: begin
                    tick_cnt <= tick_cnt_new;
                    // The new count overrides any decrement from a same-cycle read.
                    if (frame_idx < num_frames_r) begin
                        remaining <= cnt_rdata;
                        frame_idx <= frame_idx + 1'b1;
                    end else begin
                        remaining <= '0;
                    end
                    if (tick_cnt_new > TW'(NUM_LAYERS)) begin
                        spike_vec       <= acc;
                        spike_frame     <= FRAME_WIDTH'(tick_cnt_new - TW'(NUM_LAYERS + 1));
                        spike_vec_valid <= 1'b1;
                    end
                    acc      <= acc_set;
                    wait_cnt <= period_r - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Address 0 while parked so the first count is already on cnt_rdata when the run starts.
    assign cnt_addr                = (state == S_IDLE || state == S_DONE) ? '0 : frame_idx;
    assign pkt_addr                = rd_ptr;
    assign grid.packet_in          = pkt_rdata;
    assign grid.tick               = (state == S_TICK);
    assign grid.input_buffer_empty = ibe;
    assign busy                    = (state == S_INIT) || active;
    assign done                    = (state == S_DONE);
    assign state_dbg               = state;
endmodule

// File: tb/tb_ranc_tick_sequencer.sv
// Directed bench for ranc_tick_sequencer: behavioural count/packet ROMs, a greedy grid
// model that reads whenever the buffer is non-empty, and per-scenario checks.
module tb_ranc_tick_sequencer;
  logic         clk;
  logic         rst;
  logic         start;
  logic [13:0]  num_frames;
  logic [15:0]  tick_period;
  logic [15:0]  init_wait;
  logic [13:0]  cnt_addr;
  logic [6:0]   cnt_rdata;
  logic [11:0]  pkt_addr;
  logic [29:0]  pkt_rdata;
  logic [249:0] spike_vec;
  logic         spike_vec_valid;
  logic [13:0]  spike_frame;
  logic         busy;
  logic         done;
  logic         underrun_error;
  logic [2:0]   state_dbg;

  ranc_tick_sequencer_if #(.PACKET_WIDTH(30), .OUT_ID_WIDTH(9)) gif ();

  ranc_tick_sequencer #(.OUT_ID_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .tick_period(tick_period), .init_wait(init_wait),
    .cnt_addr(cnt_addr), .cnt_rdata(cnt_rdata),
    .pkt_addr(pkt_addr), .pkt_rdata(pkt_rdata),
    .grid(gif),
    .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid), .spike_frame(spike_frame),
    .busy(busy), .done(done), .underrun_error(underrun_error), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous ROMs
  logic [6:0] cnt_rom [16384];
  always @(posedge clk) cnt_rdata <= cnt_rom[cnt_addr];
  always @(posedge clk) pkt_rdata <= {18'h2A5A5, pkt_addr};

  function automatic logic [29:0] pkt_val(input int a);
    logic [11:0] a12;
    a12 = 12'(a);
    return {18'h2A5A5, a12};
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  // observation records, cycle 0 = cycle in which start is sampled
  int            cyc;
  logic          xfer_prev;
  int            tick_at[$];
  logic [29:0]   rx_q[$];
  int            rx_t_q[$];
  logic [249:0]  sv_q[$];
  logic [13:0]   sf_q[$];
  logic          ibe_h [256];
  logic          done_h [256];
  logic          und_h [256];
  logic [11:0]   pa_h [256];
  logic          ren_plan [256];
  int            spk_plan [256];
  logic [29:0]   exp_q[$];
  int            exp_t_q[$];

  // driver tasks
  task automatic do_start(input int nf, input int per, input int iw);
    @(negedge clk);
    tick_at.delete(); rx_q.delete(); rx_t_q.delete(); sv_q.delete(); sf_q.delete();
    exp_q.delete(); exp_t_q.delete();
    for (int i = 0; i < 256; i++) begin
      ren_plan[i] = 1'b0;
      spk_plan[i] = -1;
    end
    cyc = 0;
    xfer_prev = 1'b0;
    num_frames = 14'(nf);
    tick_period = 16'(per);
    init_wait = 16'(iw);
    start = 1'b1;
    gif.ren_to_input_buffer = 1'b0;
    gif.packet_out_valid = 1'b0;
  endtask

  task automatic drive_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (xfer_prev) begin
        rx_q.push_back(gif.packet_in);
        rx_t_q.push_back(tick_at.size());
      end
      if (gif.tick) tick_at.push_back(cyc);
      if (spike_vec_valid) begin
        sv_q.push_back(spike_vec);
        sf_q.push_back(spike_frame);
      end
      if (cyc < 256) begin
        ibe_h[cyc] = gif.input_buffer_empty;
        done_h[cyc] = done;
        und_h[cyc] = underrun_error;
        pa_h[cyc] = pkt_addr;
      end
      gif.ren_to_input_buffer = !gif.input_buffer_empty || (cyc < 256 && ren_plan[cyc]);
      xfer_prev = gif.ren_to_input_buffer && !gif.input_buffer_empty;
      if (cyc < 256 && spk_plan[cyc] >= 0) begin
        gif.packet_out_valid = 1'b1;
        gif.packet_out = 9'(spk_plan[cyc]);
      end else begin
        gif.packet_out_valid = 1'b0;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; num_frames = '0; tick_period = '0; init_wait = '0;
    gif.ren_to_input_buffer = 1'b0; gif.packet_out_valid = 1'b0; gif.packet_out = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, gif.tick, gif.input_buffer_empty, spike_vec_valid, underrun_error} !== 6'b000100) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000100",
               {busy, done, gif.tick, gif.input_buffer_empty, spike_vec_valid, underrun_error});
    end
    n_cmp++;
    if (spike_vec !== '0 || spike_frame !== '0 || pkt_addr !== '0 || cnt_addr !== '0 || state_dbg !== 3'd0) begin
      n_err++;
      $display("FAIL reset_values: got vec=%h frame=%0d pa=%0d ca=%0d st=%0d expected all 0",
               spike_vec, spike_frame, pkt_addr, cnt_addr, state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    cnt_rom[0] = 7'd3;
    do_start(1, 20, 5);
    drive_cycles(30);
    n_cmp++;
    if (tick_at.size() !== 2 || tick_at[0] !== 6 || tick_at[1] !== 26) begin
      n_err++;
      $display("FAIL single_ticks: got n=%0d first=%0d second=%0d expected n=2 at 6 and 26",
               tick_at.size(), tick_at.size() > 0 ? tick_at[0] : -1, tick_at.size() > 1 ? tick_at[1] : -1);
    end
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(pkt_val(a));
      exp_t_q.push_back(1);
    end
    n_cmp++;
    if (rx_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL single_pkt_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i] || rx_t_q[i] !== exp_t_q[i]) begin
        n_err++;
        $display("FAIL single_pkt[%0d]: got %h after tick %0d expected %h after tick %0d",
                 i, rx_q[i], rx_t_q[i], exp_q[i], exp_t_q[i]);
      end
    end
    n_cmp++;
    if (ibe_h[10] !== 1'b1 || ibe_h[25] !== 1'b1) begin
      n_err++;
      $display("FAIL single_empty_after: got %b%b expected 11", ibe_h[10], ibe_h[25]);
    end
    n_cmp++;
    if (done_h[26] !== 1'b0 || done_h[27] !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got c26=%b c27=%b expected 0 1", done_h[26], done_h[27]);
    end
    n_cmp++;
    if (sv_q.size() !== 1 || sf_q[0] !== 14'd0 || sv_q[0] !== '0) begin
      n_err++;
      $display("FAIL single_spike_out: got n=%0d expected one empty frame-0 vector", sv_q.size());
    end
  endtask

  task automatic test_spike_mapping();
    logic [249:0] e0;
    logic [249:0] e1;
    cnt_rom[0] = 7'd0;
    cnt_rom[1] = 7'd0;
    do_start(2, 8, 0);
    spk_plan[3] = 0;
    spk_plan[4] = 249;
    spk_plan[5] = 300;
    spk_plan[6] = 250;
    spk_plan[9] = 5;
    spk_plan[12] = 7;
    drive_cycles(20);
    e0 = '0; e0[249] = 1'b1; e0[0] = 1'b1;
    e1 = '0; e1[244] = 1'b1; e1[242] = 1'b1;
    n_cmp++;
    if (tick_at.size() !== 3 || tick_at[0] !== 1) begin
      n_err++;
      $display("FAIL spike_ticks: got n=%0d first=%0d expected n=3 first=1",
               tick_at.size(), tick_at.size() > 0 ? tick_at[0] : -1);
    end
    n_cmp++;
    if (sv_q.size() !== 2) begin
      n_err++;
      $display("FAIL spike_pulses: got %0d expected 2", sv_q.size());
    end else begin
      n_cmp++;
      if (sv_q[0] !== e0 || sf_q[0] !== 14'd0) begin
        n_err++;
        $display("FAIL spike_frame0: got %h frame %0d expected %h frame 0", sv_q[0], sf_q[0], e0);
      end
      n_cmp++;
      if (sv_q[1] !== e1 || sf_q[1] !== 14'd1) begin
        n_err++;
        $display("FAIL spike_frame1: got %h frame %0d expected %h frame 1", sv_q[1], sf_q[1], e1);
      end
    end
  endtask

  task automatic test_zero_count();
    logic all_empty;
    cnt_rom[0] = 7'd2;
    cnt_rom[1] = 7'd0;
    cnt_rom[2] = 7'd4;
    do_start(3, 10, 2);
    drive_cycles(36);
    n_cmp++;
    if (tick_at.size() !== 4 || tick_at[0] !== 3 || tick_at[3] !== 33) begin
      n_err++;
      $display("FAIL zero_ticks: got n=%0d expected 4 ticks at 3..33", tick_at.size());
    end
    all_empty = 1'b1;
    for (int c = 13; c <= 23; c++) all_empty &= ibe_h[c];
    n_cmp++;
    if (all_empty !== 1'b1) begin
      n_err++;
      $display("FAIL zero_frame1_empty: got %b expected 1", all_empty);
    end
    exp_q.push_back(pkt_val(0)); exp_t_q.push_back(1);
    exp_q.push_back(pkt_val(1)); exp_t_q.push_back(1);
    for (int a = 2; a < 6; a++) begin
      exp_q.push_back(pkt_val(a));
      exp_t_q.push_back(3);
    end
    n_cmp++;
    if (rx_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL zero_pkt_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i] || rx_t_q[i] !== exp_t_q[i]) begin
        n_err++;
        $display("FAIL zero_pkt[%0d]: got %h after tick %0d expected %h after tick %0d",
                 i, rx_q[i], rx_t_q[i], exp_q[i], exp_t_q[i]);
      end
    end
  endtask

  task automatic test_underrun();
    cnt_rom[0] = 7'd2;
    do_start(1, 10, 1);
    ren_plan[7] = 1'b1;
    drive_cycles(16);
    n_cmp++;
    if (tick_at.size() !== 2 || tick_at[0] !== 2 || tick_at[1] !== 12) begin
      n_err++;
      $display("FAIL underrun_ticks: got n=%0d expected ticks at 2 and 12", tick_at.size());
    end
    n_cmp++;
    if (und_h[6] !== 1'b0 || und_h[8] !== 1'b1 || und_h[15] !== 1'b1) begin
      n_err++;
      $display("FAIL underrun_flag: got c6=%b c8=%b c15=%b expected 0 1 1", und_h[6], und_h[8], und_h[15]);
    end
    n_cmp++;
    if (pa_h[6] !== 12'd2 || pa_h[8] !== 12'd2) begin
      n_err++;
      $display("FAIL underrun_ptr: got c6=%0d c8=%0d expected 2 2", pa_h[6], pa_h[8]);
    end
    // a fresh start (zero frames) clears the sticky error
    do_start(0, 10, 0);
    drive_cycles(5);
    n_cmp++;
    if (und_h[1] !== 1'b0) begin
      n_err++;
      $display("FAIL underrun_clear: got %b expected 0", und_h[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [249:0] e;
    for (int f = 0; f < 3; f++) cnt_rom[f] = 7'd3;
    do_start(3, 10, 0);
    spk_plan[4] = 10;
    drive_cycles(13);
    e = '0; e[239] = 1'b1;
    n_cmp++;
    if (spike_vec !== e || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_before: got vec=%h busy=%b expected %h busy=1", spike_vec, busy, e);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, gif.tick, gif.input_buffer_empty, spike_vec_valid, underrun_error} !== 6'b000100
        || state_dbg !== 3'd0) begin
      n_err++;
      $display("FAIL midrun_async_flags: got %b st=%0d expected 000100 st=0",
               {busy, done, gif.tick, gif.input_buffer_empty, spike_vec_valid, underrun_error}, state_dbg);
    end
    n_cmp++;
    if (spike_vec !== '0 || pkt_addr !== '0 || cnt_addr !== '0) begin
      n_err++;
      $display("FAIL midrun_async_values: got vec=%h pa=%0d ca=%0d expected 0", spike_vec, pkt_addr, cnt_addr);
    end
    gif.ren_to_input_buffer = 1'b0;
    gif.packet_out_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_start(1, 10, 0);
    drive_cycles(14);
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(pkt_val(a));
      exp_t_q.push_back(1);
    end
    n_cmp++;
    if (tick_at.size() !== 2 || tick_at[0] !== 1 || rx_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL restart_shape: got ticks=%0d pkts=%0d expected ticks=2 pkts=3", tick_at.size(), rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i] || rx_t_q[i] !== exp_t_q[i]) begin
        n_err++;
        $display("FAIL restart_pkt[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (sf_q.size() !== 1 || sf_q[0] !== 14'd0) begin
      n_err++;
      $display("FAIL restart_frame: got n=%0d expected one frame-0 capture", sf_q.size());
    end
  endtask

  task automatic test_period_boundary();
    cnt_rom[0] = 7'd1;
    cnt_rom[1] = 7'd1;
    do_start(2, 1, 0);
    drive_cycles(8);
    n_cmp++;
    if (tick_at.size() !== 3 || tick_at[0] !== 1 || tick_at[1] !== 3 || tick_at[2] !== 5) begin
      n_err++;
      $display("FAIL period_min_ticks: got n=%0d expected ticks at 1 3 5", tick_at.size());
    end
    n_cmp++;
    if (done_h[5] !== 1'b0 || done_h[6] !== 1'b1) begin
      n_err++;
      $display("FAIL period_min_done: got c5=%b c6=%b expected 0 1", done_h[5], done_h[6]);
    end
    n_cmp++;
    if (rx_q.size() !== 2 || rx_q[0] !== pkt_val(0) || rx_q[1] !== pkt_val(1)) begin
      n_err++;
      $display("FAIL period_min_pkts: got n=%0d expected 2 packets rom[0..1]", rx_q.size());
    end
    do_start(0, 10, 3);
    drive_cycles(6);
    n_cmp++;
    if (tick_at.size() !== 0 || done_h[1] !== 1'b1) begin
      n_err++;
      $display("FAIL zero_frames: got ticks=%0d done=%b expected 0 ticks done=1", tick_at.size(), done_h[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) cnt_rom[i] = '0;
    test_reset();
    test_single_frame();
    test_spike_mapping();
    test_zero_count();
    test_underrun();
    test_reset_mid_run();
    test_period_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
